// File: rtl/wash_phase_timer.sv
// Per-phase countdown timer closing the wash FSM timing loop.
// Optional lid pause: define PHASE_TIMER_LID_PAUSE_EN.
module wash_phase_timer #(
  parameter int PRESCALE    = 1000,
  parameter int SOAK_TICKS  = 300,
  parameter int WASH_TICKS  = 600,
  parameter int RINSE_TICKS = 300,
  parameter int SPIN_TICKS  = 200,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_enable,
  input  logic [1:0]       phase_sel,
  input  logic             power_on,
`ifdef PHASE_TIMER_LID_PAUSE_EN
  input  logic             lid,
`endif
  output logic             timer_done,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       cur_phase,
  output logic             busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXP
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       phase_q, phase_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic             cnt_en;

  // Zero-length phases still take one tick.
  function automatic logic [CNT_W-1:0] dur(input logic [1:0] p);
    int t;
    case (p)
      2'b00:   t = SOAK_TICKS;
      2'b01:   t = WASH_TICKS;
      2'b10:   t = RINSE_TICKS;
      default: t = SPIN_TICKS;
    endcase
    return (t == 0) ? CNT_W'(1) : CNT_W'(t);
  endfunction

  assign tick = (pre_q == PRE_MAX);

`ifdef PHASE_TIMER_LID_PAUSE_EN
  assign cnt_en = ~lid;
`else
  assign cnt_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    pre_d   = tick ? '0 : pre_q;
    unique case (state_q)
      S_IDLE: begin
        rem_d  = '0;
        busy_d = 1'b0;
        if (timer_enable) begin
          rem_d   = dur(phase_sel);
          phase_d = phase_sel;
          pre_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!timer_enable) begin
          rem_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (phase_sel != phase_q) begin
          rem_d   = dur(phase_sel);
          phase_d = phase_sel;
          pre_d   = '0;
          busy_d  = 1'b1;
        end else if (!cnt_en) begin
          pre_d = pre_q;
        end else if (tick) begin
          if (rem_q <= CNT_W'(1)) begin
            rem_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_EXP;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_EXP: begin
        rem_d  = '0;
        busy_d = 1'b0;
        if (!timer_enable) begin
          state_d = S_IDLE;
        end else if (phase_sel != phase_q) begin
          rem_d   = dur(phase_sel);
          phase_d = phase_sel;
          pre_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        rem_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Power loss freezes everything, including a pending done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      rem_q   <= '0;
      phase_q <= 2'b00;
      busy_q  <= 1'b0;
      pre_q   <= '0;
    end else if (power_on) begin
      state_q <= state_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
    end
  end

  assign timer_done = done_q;
  assign remaining  = rem_q;
  assign cur_phase  = phase_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer: expected done pulses are
// queued by the stimulus and matched by a monitor on the falling edge.
module tb_wash_phase_timer;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    ph;
  logic          pwr;
`ifdef PHASE_TIMER_LID_PAUSE_EN
  logic          lid;
`endif
  logic          done;
  logic [CW-1:0] rem;
  logic [1:0]    cph;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    int         width;
  } exp_t;

  exp_t q[$];

  wash_phase_timer #(
    .PRESCALE(4), .SOAK_TICKS(3), .WASH_TICKS(2),
    .RINSE_TICKS(2), .SPIN_TICKS(0), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .timer_enable(en),
    .phase_sel(ph),
    .power_on(pwr),
`ifdef PHASE_TIMER_LID_PAUSE_EN
    .lid(lid),
`endif
    .timer_done(done),
    .remaining(rem),
    .cur_phase(cph),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, expv, edges);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one entry per rising timer_done, checks width at fall.
  logic prev_done = 1'b0;
  int   wcnt = 0;
  int   wexp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
        wexp = 0;
      end else begin
        e = q.pop_front();
        chk("done_edge", edges, e.cyc);
        chk("done_phase", int'(cph), int'(e.ph));
        wexp = e.width;
      end
      wcnt = 1;
    end else if (done) begin
      wcnt++;
    end else if (prev_done && wexp != 0) begin
      chk("done_width", wcnt, wexp);
      wexp = 0;
    end
    prev_done = done;
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    ph  = 2'b00;
    pwr = 1'b1;
`ifdef PHASE_TIMER_LID_PAUSE_EN
    lid = 1'b0;
`endif
    step(2);
    chk("rst_rem", int'(rem), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_phase", int'(cph), 0);
    rst = 1'b0;
    step(1);

    // Soak expiry
    en = 1'b1; ph = 2'b00;
    q.push_back('{edges + 13, 2'b00, 1});
    step(1);
    chk("t1_load_rem", int'(rem), 3);
    chk("t1_load_busy", int'(busy), 1);
    chk("t1_load_phase", int'(cph), 0);
    step(4); chk("t1_rem2", int'(rem), 2);
    step(4); chk("t1_rem1", int'(rem), 1);
    step(4); chk("t1_rem0", int'(rem), 0);
    chk("t1_busy_end", int'(busy), 0);
    en = 1'b0;
    step(2);
    chk("t1_idle_rem", int'(rem), 0);

    // Power freeze, then freeze across the done cycle
    en = 1'b1; ph = 2'b00;
    q.push_back('{edges + 18, 2'b00, 4});
    step(5); chk("t2_rem", int'(rem), 2);
    pwr = 1'b0;
    step(5); chk("t2_frozen_rem", int'(rem), 2);
    pwr = 1'b1;
    step(8); chk("t2_done", int'(done), 1);
    pwr = 1'b0;
    step(3); chk("t2_done_held", int'(done), 1);
    pwr = 1'b1;
    step(1); chk("t2_done_clr", int'(done), 0);
    en = 1'b0;
    step(2);

    // Cancel with remaining=2
    en = 1'b1; ph = 2'b00;
    step(5); chk("t3_rem", int'(rem), 2);
    en = 1'b0;
    step(1);
    chk("t3_rem0", int'(rem), 0);
    chk("t3_busy0", int'(busy), 0);
    step(16);

    // Phase chaining soak -> wash -> spin(0 => 1 tick)
    en = 1'b1; ph = 2'b00;
    q.push_back('{edges + 13, 2'b00, 1});
    step(13);
    ph = 2'b01;
    q.push_back('{edges + 9, 2'b01, 1});
    step(1);
    chk("t4_wash_rem", int'(rem), 2);
    chk("t4_wash_phase", int'(cph), 1);
    step(8);
    ph = 2'b11;
    q.push_back('{edges + 5, 2'b11, 1});
    step(1);
    chk("t4_spin_rem", int'(rem), 1);
    chk("t4_spin_phase", int'(cph), 3);
    step(4);
    en = 1'b0;
    step(1);
    chk("t4_idle_busy", int'(busy), 0);
    chk("t4_idle_rem", int'(rem), 0);
    chk("t4_idle_done", int'(done), 0);

    // Mid-run phase change, then phase change together with disable
    en = 1'b1; ph = 2'b00;
    step(9); chk("t5_rem1", int'(rem), 1);
    ph = 2'b10;
    q.push_back('{edges + 9, 2'b10, 1});
    step(1);
    chk("t5_reload_rem", int'(rem), 2);
    chk("t5_reload_phase", int'(cph), 2);
    step(8);
    en = 1'b0; ph = 2'b01;
    step(1);
    chk("t5_idle_rem", int'(rem), 0);
    chk("t5_idle_busy", int'(busy), 0);
    step(12);

    // Reset mid-run
    en = 1'b1; ph = 2'b00;
    step(5); chk("t6_rem", int'(rem), 2);
    rst = 1'b1;
    step(1);
    chk("t6_rem0", int'(rem), 0);
    chk("t6_busy0", int'(busy), 0);
    chk("t6_phase0", int'(cph), 0);
    chk("t6_done0", int'(done), 0);
    rst = 1'b0; en = 1'b0;
    step(16);

`ifdef PHASE_TIMER_LID_PAUSE_EN
    en = 1'b1; ph = 2'b00;
    q.push_back('{edges + 16, 2'b00, 1});
    step(5);
    lid = 1'b1;
    step(3);
    chk("t7_lid_rem", int'(rem), 2);
    lid = 1'b0;
    step(8);
    en = 1'b0;
    step(4);
`endif

    step(4);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
Phase-duration timer that sits directly beside the washing-machine control FSM and closes its timing loop. It consumes the FSM's timer_enable and phase_sel outputs and returns timer_done. For the active phase it loads a per-phase duration and counts it down on a prescaled tick. It freezes whenever power_on is low, so that no completion is lost while the FSM is also frozen.

Parameters:
PRESCALE, 1000, clock cycles per timer tick (>=1)
SOAK_TICKS, 300, duration of phase 2'b00 in ticks
WASH_TICKS, 600, duration of phase 2'b01 in ticks
RINSE_TICKS, 300, duration of phase 2'b10 in ticks
SPIN_TICKS, 200, duration of phase 2'b11 in ticks
CNT_W, 16, width of the remaining-tick counter (must hold the largest *_TICKS)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
timer_enable  in  1  FSM request to time the current phase
phase_sel  in  2  phase being timed (00 soak, 01 wash, 10 rinse, 11 spin)
power_on  in  1  1 = run; 0 = freeze every register
timer_done  out  1  phase expiry pulse, registered
remaining  out  CNT_W  ticks left in the current phase, registered
cur_phase  out  2  phase latched at the last load, registered
busy  out  1  high in RUN, registered

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, timer_done 0, remaining 0, cur_phase 00, busy 0, prescale counter 0.
- Priority per edge: rst, then power_on==0 (all registers hold, timer_done included), then the FSM below.
- Duration lookup dur(p): the *_TICKS parameter for phase p. A parameter value of 0 is treated as 1.
- LOAD action:
  - remaining <= dur(phase_sel)
  - cur_phase <= phase_sel
  - prescale counter <= 0
  - busy <= 1
- Tick: asserted combinationally when the prescale counter == PRESCALE-1.
  - On a tick, the prescale counter wraps to 0.
  - Otherwise it increments in RUN only.
- States:
  - IDLE
    - timer_enable==1: LOAD, go to RUN.
    - Else: hold, remaining 0, busy 0.
  - RUN
    - timer_enable==0: go to IDLE, remaining <= 0, no timer_done (cancel path).
    - Else if phase_sel != cur_phase: LOAD the new phase (restart), stay in RUN.
    - Else on a tick: remaining decrements. If remaining was 1, set remaining <= 0, timer_done <= 1, busy <= 0, go to EXPIRED.
  - EXPIRED
    - timer_done returns to 0 on the next running edge, so the pulse is exactly one powered cycle.
    - timer_enable==0: go to IDLE.
    - Else if phase_sel != cur_phase: LOAD, go to RUN.
    - Else: hold with remaining 0 and no further pulses.
- Latency:
  - With power_on held high, timer_done is high during the cycle that follows the clock edge N*PRESCALE edges after the load edge, where N = dur(phase).
  - Every cycle with power_on low adds exactly one cycle to this latency.
- Boundary conditions:
  - timer_done is guaranteed high on a cycle where power_on is high, because it is held through freeze. The FSM therefore always sees it.
  - SPIN expiry with the FSM returning to IDLE: timer_enable drops on the next cycle, and the timer goes EXPIRED to IDLE.
  - Phase changes arriving together with timer_enable=0: go to IDLE (enable wins).
  - remaining never underflows.
  - rst mid-RUN: outputs reach their reset values on that edge, with no timer_done.

Optional Feature:
PHASE_TIMER_LID_PAUSE_EN
- Defined:
  - Adds input port lid (1 bit, 1 = open).
  - While lid==1 in RUN, the prescale counter and remaining hold; this is treated like a freeze, but local to counting only.
  - Enable/phase-change handling and timer_done clearing still operate.
- Not defined:
  - The lid port is absent, and counting depends on power_on only.

Test Plan:
(Bench parameters: PRESCALE=4, SOAK_TICKS=3, WASH_TICKS=2, RINSE_TICKS=2, SPIN_TICKS=0.)
1. Soak expiry: timer_enable=1, phase_sel=00 from IDLE -> cur_phase=00, remaining=3. remaining reads 2, then 1, then 0, each 4 cycles apart. timer_done is high for exactly 1 cycle, 12 edges after load.
2. Power freeze: as 1, but power_on=0 for 5 cycles mid-run -> remaining is frozen during the gap and timer_done arrives 17 edges after load. With power_on=0 on the done cycle, timer_done stays high until the first powered edge.
3. Cancel: timer_enable drops with remaining=2 -> next edge gives IDLE, remaining=0, busy=0, and timer_done never asserts.
4. Phase chaining: after the soak pulse, phase_sel=01 -> reload remaining=2, done 8 edges later. Then phase_sel=11 with SPIN_TICKS=0 -> done 4 edges later.
5. Mid-run phase change: phase_sel switches from 00 to 10 with remaining=1 -> reload remaining=2, prescaler restarts, done 8 edges later with cur_phase=10.
6. Reset mid-run: rst=1 for one edge at remaining=2 -> all outputs 0. With PHASE_TIMER_LID_PAUSE_EN defined, lid=1 for 3 cycles delays done by 3.
